universal_shift_counter: RTL and testbench

UNIVERSAL_SHIFT_COUNTER -- requirements
Module: universal_shift_counter

---
 rtl/universal_shift_counter.sv | 163 ++++++++++++++++
 tb/tb_universal_shift_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_counter.sv
// -----------------------------------------------------------------------------
// universal_shift_counter
//
// SIZE-bit register that can count up or down against a programmable
// terminal value (modulus Limit+1), or shift, rotate and arithmetic-shift by
// one position per enabled cycle. A sticky Overflow flag records any count
// boundary event until the next Reset or Load.
//
// Parameters
//   SIZE      register width in bits (>= 2)
//   SATURATE  0: count modes wrap at the boundary, 1: count modes clamp
//
// Ports
//   Clock         in   rising-edge clock
//   Reset         in   synchronous active-high reset (Q <= Initial, Overflow <= 0)
//   Initial       in   value loaded on Reset or Load
//   Load          in   synchronous parallel load of Initial, clears Overflow
//   Enable        in   advance the register by one step of Mode
//   Mode          in   000 hold, 001 up, 010 down, 011 shl, 100 shr,
//                      101 rol, 110 ror, 111 asr
//   Limit         in   count terminal value
//   SerialIn      in   bit inserted by the shift modes
//   Q             out  registered contents
//   SerialOut     out  Q[SIZE-1] for Mode 011/101, otherwise Q[0]
//   TerminalCount out  up-count at/above Limit, or down-count at zero
//   Overflow      out  registered sticky count-boundary flag
// -----------------------------------------------------------------------------
module universal_shift_counter #(
    parameter int SIZE     = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [SIZE-1:0] Initial,
    input  logic            Load,
    input  logic            Enable,
    input  logic [2:0]      Mode,
    input  logic [SIZE-1:0] Limit,
    input  logic            SerialIn,
    output logic [SIZE-1:0] Q,
    output logic            SerialOut,
    output logic            TerminalCount,
    output logic            Overflow
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_UP   = 3'b001;
    localparam logic [2:0] MODE_DOWN = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_SHR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_ASR  = 3'b111;

    localparam logic [SIZE-1:0] ZERO_C = {SIZE{1'b0}};
    localparam logic [SIZE-1:0] ONE_C  = {{(SIZE-1){1'b0}}, 1'b1};

    logic [SIZE-1:0] q_r;
    logic            overflow_r;
    logic [SIZE-1:0] next_q_s;
    logic            boundary_s;

    // Next value for one enabled step of the selected mode, plus boundary detect.
    always_comb begin
        next_q_s   = q_r;
        boundary_s = 1'b0;
        case (Mode)
            MODE_HOLD: begin
                next_q_s = q_r;
            end
            MODE_UP: begin
                // ">=" so a value above Limit (e.g. after a Load) still wraps/clamps.
                if (q_r >= Limit) begin
                    boundary_s = 1'b1;
                    if (SATURATE == 1'b1) begin
                        next_q_s = Limit;
                    end else begin
                        next_q_s = ZERO_C;
                    end
                end else begin
                    next_q_s = q_r + ONE_C;
                end
            end
            MODE_DOWN: begin
                // Values above Limit simply decrement until zero is reached.
                if (q_r == ZERO_C) begin
                    boundary_s = 1'b1;
                    if (SATURATE == 1'b1) begin
                        next_q_s = ZERO_C;
                    end else begin
                        next_q_s = Limit;
                    end
                end else begin
                    next_q_s = q_r - ONE_C;
                end
            end
            MODE_SHL: begin
                next_q_s = {q_r[SIZE-2:0], SerialIn};
            end
            MODE_SHR: begin
                next_q_s = {SerialIn, q_r[SIZE-1:1]};
            end
            MODE_ROL: begin
                next_q_s = {q_r[SIZE-2:0], q_r[SIZE-1]};
            end
            MODE_ROR: begin
                next_q_s = {q_r[0], q_r[SIZE-1:1]};
            end
            MODE_ASR: begin
                next_q_s = {q_r[SIZE-1], q_r[SIZE-1:1]};
            end
            default: begin
                next_q_s = q_r;
            end
        endcase
    end

    // Register and sticky flag update with Reset > Load > Enable priority.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_r        <= Initial;
            overflow_r <= 1'b0;
        end else if (Load) begin
            q_r        <= Initial;
            overflow_r <= 1'b0;
        end else if (Enable) begin
            q_r <= next_q_s;
            if (boundary_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end else begin
            q_r        <= q_r;
            overflow_r <= overflow_r;
        end
    end

    // Combinational status taps decoded from the current Mode and register.
    always_comb begin
        SerialOut     = q_r[0];
        TerminalCount = 1'b0;
        case (Mode)
            MODE_UP: begin
                TerminalCount = (q_r >= Limit);
            end
            MODE_DOWN: begin
                TerminalCount = (q_r == ZERO_C);
            end
            MODE_SHL, MODE_ROL: begin
                SerialOut = q_r[SIZE-1];
            end
            default: begin
                SerialOut     = q_r[0];
                TerminalCount = 1'b0;
            end
        endcase
    end

    assign Q        = q_r;
    assign Overflow = overflow_r;

endmodule

// File: tb/tb_universal_shift_counter.sv
module tb_universal_shift_counter;

    typedef struct packed {
        int         id;
        logic       dut;
        logic [7:0] q;
        logic       ovf;
        logic       tc;
        logic       so;
    } exp_t;

    logic       clk;
    logic       rst  [2];
    logic       ld   [2];
    logic       en   [2];
    logic [2:0] mode [2];
    logic [7:0] init [2];
    logic [7:0] lim  [2];
    logic       si   [2];
    logic [7:0] q    [2];
    logic       so   [2];
    logic       tc   [2];
    logic       ovf  [2];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    universal_shift_counter #(.SIZE(8), .SATURATE(1'b0)) dut_wrap (
        .Clock(clk), .Reset(rst[0]), .Initial(init[0]), .Load(ld[0]),
        .Enable(en[0]), .Mode(mode[0]), .Limit(lim[0]), .SerialIn(si[0]),
        .Q(q[0]), .SerialOut(so[0]), .TerminalCount(tc[0]), .Overflow(ovf[0])
    );

    universal_shift_counter #(.SIZE(8), .SATURATE(1'b1)) dut_sat (
        .Clock(clk), .Reset(rst[1]), .Initial(init[1]), .Load(ld[1]),
        .Enable(en[1]), .Mode(mode[1]), .Limit(lim[1]), .SerialIn(si[1]),
        .Q(q[1]), .SerialOut(so[1]), .TerminalCount(tc[1]), .Overflow(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs to the selected DUT (other stays idle).
    task automatic drive(input int d, input logic r, input logic l, input logic e,
                         input logic [2:0] m, input logic [7:0] iv,
                         input logic [7:0] lv, input logic s);
        rst[d]  = r;
        ld[d]   = l;
        en[d]   = e;
        mode[d] = m;
        init[d] = iv;
        lim[d]  = lv;
        si[d]   = s;
    endtask

    // Push what the selected DUT must show during the current cycle.
    task automatic expect_now(input int d, input logic [7:0] eq, input logic eo,
                              input logic et, input logic es);
        exp_t e;
        e.id  = vec_id;
        e.dut = (d != 0);
        e.q   = eq;
        e.ovf = eo;
        e.tc  = et;
        e.so  = es;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, pop and compare every pending expectation.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                d = e.dut ? 1 : 0;
                checks++;
                if (q[d] !== e.q) begin
                    errors++;
                    $display("FAIL vec%0d dut%0d Q: got %h expected %h", e.id, d, q[d], e.q);
                end
                checks++;
                if (ovf[d] !== e.ovf) begin
                    errors++;
                    $display("FAIL vec%0d dut%0d Overflow: got %b expected %b", e.id, d, ovf[d], e.ovf);
                end
                checks++;
                if (tc[d] !== e.tc) begin
                    errors++;
                    $display("FAIL vec%0d dut%0d TerminalCount: got %b expected %b", e.id, d, tc[d], e.tc);
                end
                checks++;
                if (so[d] !== e.so) begin
                    errors++;
                    $display("FAIL vec%0d dut%0d SerialOut: got %b expected %b", e.id, d, so[d], e.so);
                end
            end
        end
    end

    initial begin
        logic [7:0] qv;
        logic       ov;
        logic       tv;
        logic       sv;
        int         waited;

        for (int k = 0; k < 2; k++) begin
            drive(k, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        end
        tick();

        // ---------------- wrapping instance (SATURATE=0) ----------------
        // Reset overrides Enable; first step after reset acts on Initial.
        drive(0, 1'b1, 1'b0, 1'b1, 3'b001, 8'h5A, 8'hFF, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h5A, 8'hFF, 1'b0); expect_now(0, 8'h5A, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h5A, 8'hFF, 1'b0); expect_now(0, 8'h5B, 1'b0, 1'b0, 1'b1); tick();

        // Load 0 (Enable ignored), then count modulo 10 for 12 cycles.
        drive(0, 1'b0, 1'b1, 1'b1, 3'b001, 8'h00, 8'h09, 1'b0); expect_now(0, 8'h5B, 1'b0, 1'b1, 1'b1); tick();
        for (int i = 0; i < 12; i++) begin
            qv = (i <= 9) ? 8'(i) : 8'(i - 10);
            ov = (i >= 10);
            tv = (qv == 8'h09);
            drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h00, 8'h09, 1'b0);
            expect_now(0, qv, ov, tv, qv[0]);
            tick();
        end
        drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 8'h09, 1'b0); expect_now(0, 8'h02, 1'b1, 1'b0, 1'b0); tick();

        // Shift / rotate / arithmetic shift vectors.
        drive(0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h81, 8'h09, 1'b0); expect_now(0, 8'h02, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b011, 8'h81, 8'h09, 1'b0); expect_now(0, 8'h81, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b1, 1'b0, 3'b101, 8'h81, 8'h09, 1'b0); expect_now(0, 8'h02, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b101, 8'h81, 8'h09, 1'b0); expect_now(0, 8'h81, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h81, 8'h09, 1'b0); expect_now(0, 8'h03, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b111, 8'h81, 8'h09, 1'b0); expect_now(0, 8'h81, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b100, 8'h81, 8'h09, 1'b1); expect_now(0, 8'hC0, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b110, 8'h81, 8'h09, 1'b0); expect_now(0, 8'hE0, 1'b0, 1'b0, 1'b0); tick();

        // Limit = 0: Q pinned at 0, Overflow set; shift keeps Overflow.
        drive(0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h05, 8'h00, 1'b0); expect_now(0, 8'h70, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h05, 8'h00, 1'b0); expect_now(0, 8'h05, 1'b0, 1'b1, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h05, 8'h00, 1'b0); expect_now(0, 8'h00, 1'b1, 1'b1, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b011, 8'h05, 8'h00, 1'b1); expect_now(0, 8'h00, 1'b1, 1'b0, 1'b0); tick();

        // Enable low while Mode cycles through all eight codes: nothing moves.
        for (int m = 0; m < 8; m++) begin
            tv = (m == 1);
            sv = (m == 3 || m == 5) ? 1'b0 : 1'b1;
            drive(0, 1'b0, 1'b0, 1'b0, 3'(m), 8'h05, 8'h00, 1'b1);
            expect_now(0, 8'h01, 1'b1, tv, sv);
            tick();
        end

        // Down-count wrap to Limit.
        drive(0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h01, 8'h09, 1'b0); expect_now(0, 8'h01, 1'b1, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h01, 8'h09, 1'b0); expect_now(0, 8'h01, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h01, 8'h09, 1'b0); expect_now(0, 8'h00, 1'b0, 1'b1, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h01, 8'h09, 1'b0); expect_now(0, 8'h09, 1'b1, 1'b0, 1'b1); tick();

        // Down from above Limit, then immediate switch to up-count.
        drive(0, 1'b0, 1'b1, 1'b0, 3'b000, 8'h0B, 8'h09, 1'b0); expect_now(0, 8'h08, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h0B, 8'h09, 1'b0); expect_now(0, 8'h0B, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h0B, 8'h09, 1'b0); expect_now(0, 8'h0A, 1'b0, 1'b1, 1'b0); tick();

        // Reset mid-operation clears Overflow and restarts from Initial.
        drive(0, 1'b1, 1'b0, 1'b1, 3'b001, 8'h20, 8'h09, 1'b0); expect_now(0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h20, 8'hFF, 1'b0); expect_now(0, 8'h20, 1'b0, 1'b0, 1'b0); tick();

        // Reset beats Load; Load beats Enable.
        drive(0, 1'b1, 1'b1, 1'b1, 3'b001, 8'h33, 8'hFF, 1'b0); expect_now(0, 8'h21, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b1, 1'b1, 3'b001, 8'h44, 8'hFF, 1'b0); expect_now(0, 8'h33, 1'b0, 1'b0, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h44, 8'hFF, 1'b0); expect_now(0, 8'h44, 1'b0, 1'b0, 1'b0); tick();

        // Limit all-ones: full-range wrap FF -> 00.
        drive(0, 1'b0, 1'b1, 1'b0, 3'b000, 8'hFF, 8'hFF, 1'b0); expect_now(0, 8'h44, 1'b0, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 1'b0, 1'b1, 3'b001, 8'hFF, 8'hFF, 1'b0); expect_now(0, 8'hFF, 1'b0, 1'b1, 1'b1); tick();
        drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 8'hFF, 8'hFF, 1'b0); expect_now(0, 8'h00, 1'b1, 1'b0, 1'b0); tick();

        // ---------------- clamping instance (SATURATE=1) ----------------
        drive(1, 1'b1, 1'b0, 1'b0, 3'b000, 8'h01, 8'hFF, 1'b0); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b010, 8'h01, 8'hFF, 1'b0); expect_now(1, 8'h01, 1'b0, 1'b0, 1'b1); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b010, 8'h01, 8'hFF, 1'b0); expect_now(1, 8'h00, 1'b0, 1'b1, 1'b0); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b010, 8'h01, 8'hFF, 1'b0); expect_now(1, 8'h00, 1'b1, 1'b1, 1'b0); tick();
        drive(1, 1'b0, 1'b1, 1'b0, 3'b000, 8'h10, 8'hFF, 1'b0); expect_now(1, 8'h00, 1'b1, 1'b0, 1'b0); tick();
        drive(1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h10, 8'hFF, 1'b0); expect_now(1, 8'h10, 1'b0, 1'b0, 1'b0); tick();

        // Up-count clamps at Limit.
        drive(1, 1'b0, 1'b1, 1'b0, 3'b000, 8'h08, 8'h09, 1'b0); expect_now(1, 8'h10, 1'b0, 1'b0, 1'b0); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h08, 8'h09, 1'b0); expect_now(1, 8'h08, 1'b0, 1'b0, 1'b0); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h08, 8'h09, 1'b0); expect_now(1, 8'h09, 1'b0, 1'b1, 1'b1); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h08, 8'h09, 1'b0); expect_now(1, 8'h09, 1'b1, 1'b1, 1'b1); tick();
        drive(1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h08, 8'h09, 1'b0); expect_now(1, 8'h09, 1'b1, 1'b0, 1'b1); tick();

        // Up-count from above Limit clamps straight to Limit.
        drive(1, 1'b0, 1'b1, 1'b0, 3'b000, 8'h0C, 8'h09, 1'b0); expect_now(1, 8'h09, 1'b1, 1'b0, 1'b1); tick();
        drive(1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h0C, 8'h09, 1'b0); expect_now(1, 8'h0C, 1'b0, 1'b1, 1'b0); tick();
        drive(1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h0C, 8'h09, 1'b0); expect_now(1, 8'h09, 1'b1, 1'b0, 1'b1); tick();

        // Let the monitor drain, with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
